// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter.
// Sends one command byte to the attached device over the open-drain clock/data
// lines. Each line is driven low through an active-high pull-low enable and read
// back through a synchroniser plus a level filter. The byte is framed as start,
// eight data bits LSB first, odd parity and stop. The device acknowledge is then
// sampled, and the transfer ends once both lines have returned high. A watchdog
// abandons the frame if the device stalls.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 12000,
   parameter int unsigned TIMEOUT_CYCLES = 1500000,
   parameter int unsigned FILTER_LEN     = 8
) (
   input  logic       clock,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       done,
   output logic       ack_ok,
   output logic       err
);

   localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
   localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned FW = $clog2(FILTER_LEN + 1);

   localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
   localparam logic [IW-1:0] INH_PRE  = IW'(INHIBIT_CYCLES - 2);
   localparam logic [WW-1:0] TMO_LAST = WW'(TIMEOUT_CYCLES - 1);
   localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQ,
      SHIFT,
      ACK,
      WAIT_IDLE
   } state_t;

   state_t state, state_next;

   // synchroniser and filter state
   logic [1:0]    clk_sync, data_sync;
   logic          clk_filt, data_filt;
   logic [FW-1:0] clk_fcnt, data_fcnt;
   logic          fall_clk;

   // frame datapath
   logic [7:0]    data_q;
   logic          parity_q;
   logic [3:0]    bit_cnt;
   logic [IW-1:0] inh_cnt;
   logic [WW-1:0] wdog;

   // next values of registered state and outputs
   logic [7:0]    data_d;
   logic          parity_d;
   logic [3:0]    bit_cnt_d;
   logic [IW-1:0] inh_cnt_d;
   logic [WW-1:0] wdog_d;
   logic          clk_oe_d, data_oe_d, ready_d, busy_d, done_d, ack_d, err_d;

   logic          accept;
   logic          active;
   logic          timeout;

   assign accept  = tx_valid && tx_ready && (state == IDLE);
   assign active  = (state == REQ) || (state == SHIFT) || (state == ACK) || (state == WAIT_IDLE);
   assign timeout = active && (wdog == TMO_LAST);

   // Two-flop synchronisers for both raw line levels; idle lines read high.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         clk_sync  <= '1;
         data_sync <= '1;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk_i};
         data_sync <= {data_sync[0], ps2_data_i};
      end
   end

   // Clock-line level filter; also emits the one-cycle falling-edge strobe.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         clk_filt <= 1'b1;
         clk_fcnt <= '0;
         fall_clk <= 1'b0;
      end else begin
         fall_clk <= 1'b0;
         if (clk_sync[1] == clk_filt) begin
            clk_fcnt <= '0;
         end else if (clk_fcnt == FLT_LAST) begin
            clk_filt <= clk_sync[1];
            clk_fcnt <= '0;
            fall_clk <= clk_filt;
         end else begin
            clk_fcnt <= clk_fcnt + 1'b1;
         end
      end
   end

   // Data-line level filter.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         data_filt <= 1'b1;
         data_fcnt <= '0;
      end else begin
         if (data_sync[1] == data_filt) begin
            data_fcnt <= '0;
         end else if (data_fcnt == FLT_LAST) begin
            data_filt <= data_sync[1];
            data_fcnt <= '0;
         end else begin
            data_fcnt <= data_fcnt + 1'b1;
         end
      end
   end

   // State register.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; the watchdog overrides any line event in the same cycle.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (accept) state_next = INHIBIT;
         end
         INHIBIT: begin
            if (inh_cnt == INH_LAST) state_next = REQ;
         end
         REQ: begin
            if (timeout)       state_next = IDLE;
            else if (fall_clk) state_next = SHIFT;
         end
         SHIFT: begin
            if (timeout)                          state_next = IDLE;
            else if (fall_clk && bit_cnt == 4'd9) state_next = ACK;
         end
         ACK: begin
            if (timeout)       state_next = IDLE;
            else if (fall_clk) state_next = WAIT_IDLE;
         end
         WAIT_IDLE: begin
            if (timeout)                     state_next = IDLE;
            else if (clk_filt && data_filt) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Output and datapath next values.
   // The pull-low enables are computed one cycle ahead, so the registered oe
   // outputs change in the cycle after fall_clk, while the device holds the
   // clock low.
   always_comb begin
      data_d    = data_q;
      parity_d  = parity_q;
      bit_cnt_d = bit_cnt;
      inh_cnt_d = inh_cnt;
      wdog_d    = wdog;
      clk_oe_d  = ps2_clk_oe;
      data_oe_d = ps2_data_oe;
      ack_d     = ack_ok;
      err_d     = err;
      done_d    = 1'b0;
      ready_d   = (state == IDLE) && (state_next == IDLE);
      busy_d    = (state_next != IDLE);

      if (state == IDLE) begin
         if (accept) begin
            data_d    = tx_data;
            parity_d  = ~^tx_data;
            ack_d     = 1'b0;
            err_d     = 1'b0;
            clk_oe_d  = 1'b1;
            data_oe_d = 1'b0;
            inh_cnt_d = '0;
            bit_cnt_d = '0;
         end
      end else if (state == INHIBIT) begin
         inh_cnt_d = inh_cnt + 1'b1;
         if (inh_cnt == INH_PRE) data_oe_d = 1'b1;
         if (inh_cnt == INH_LAST) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b1;
            wdog_d    = '0;
         end
      end else if (timeout) begin
         clk_oe_d  = 1'b0;
         data_oe_d = 1'b0;
         ack_d     = 1'b0;
         err_d     = 1'b1;
         done_d    = 1'b1;
      end else begin
         wdog_d = fall_clk ? '0 : wdog + 1'b1;
         if (fall_clk) bit_cnt_d = bit_cnt + 1'b1;
         if (state == REQ && fall_clk) begin
            data_oe_d = ~data_q[0];
         end
         if (state == SHIFT && fall_clk) begin
            if (bit_cnt < 4'd8)       data_oe_d = ~data_q[bit_cnt[2:0]];
            else if (bit_cnt == 4'd8) data_oe_d = ~parity_q;
            else                      data_oe_d = 1'b0;
         end
         if (state == ACK && fall_clk) begin
            if (data_filt) err_d = 1'b1;
            else           ack_d = 1'b1;
         end
         if (state == WAIT_IDLE && clk_filt && data_filt) begin
            done_d = 1'b1;
         end
      end
   end

   // Registered outputs and datapath; reset releases both lines at once.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         data_q      <= '0;
         parity_q    <= 1'b0;
         bit_cnt     <= '0;
         inh_cnt     <= '0;
         wdog        <= '0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
         tx_ready    <= 1'b1;
         busy        <= 1'b0;
         done        <= 1'b0;
         ack_ok      <= 1'b0;
         err         <= 1'b0;
      end else begin
         data_q      <= data_d;
         parity_q    <= parity_d;
         bit_cnt     <= bit_cnt_d;
         inh_cnt     <= inh_cnt_d;
         wdog        <= wdog_d;
         ps2_clk_oe  <= clk_oe_d;
         ps2_data_oe <= data_oe_d;
         tx_ready    <= ready_d;
         busy        <= busy_d;
         done        <= done_d;
         ack_ok      <= ack_d;
         err         <= err_d;
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: directed frames against a PS/2 device model, with a
// scoreboard of expected completions checked whenever done pulses.
module tb_ps2_host_tx;

   localparam int INH = 120;
   localparam int TMO = 400;
   localparam int H   = 24;

   // device-sampled bits, index 0 = start ... 9 = parity, 10 = stop
   localparam logic [10:0] ED_BITS = 11'b11111011010;
   localparam logic [10:0] F4_BITS = 11'b10111101000;

   typedef struct packed {
      logic        chk_bits;
      logic [10:0] bits;
      logic        ack;
      logic        err;
   } exp_t;

   logic       clock = 1'b0;
   logic       rst;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       clk_oe, data_oe;
   logic       busy, done, ack_ok, err;
   logic       dev_clk_low, dev_data_low;
   logic       ps2_clk_line, ps2_data_line;
   logic [10:0] dev_bits;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   done_count = 0;

   assign ps2_clk_line  = ~(clk_oe | dev_clk_low);
   assign ps2_data_line = ~(data_oe | dev_data_low);

   always #5 clock = ~clock;

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .TIMEOUT_CYCLES(TMO),
      .FILTER_LEN(8)
   ) dut (
      .clock(clock),
      .rst(rst),
      .tx_data(tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .ps2_clk_i(ps2_clk_line),
      .ps2_data_i(ps2_data_line),
      .ps2_clk_oe(clk_oe),
      .ps2_data_oe(data_oe),
      .busy(busy),
      .done(done),
      .ack_ok(ack_ok),
      .err(err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every done pulse consumes one expected completion.
   logic prev_done = 1'b0;
   always @(negedge clock) begin
      exp_t e;
      if (prev_done) check("ready_after_done", {tx_ready, done}, 2'b10);
      if (done) begin
         done_count++;
         check("ready_low_at_done", tx_ready, 1'b0);
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no completion at %0t", $time);
         end else begin
            e = sb.pop_front();
            check("ack_ok", ack_ok, e.ack);
            check("err", err, e.err);
            if (e.chk_bits) check("frame_bits", dev_bits, e.bits);
         end
      end
      prev_done = done;
   end

   // Inhibit monitor: clock held low for exactly INH cycles, start bit in the last one.
   int   inh_run = 0;
   logic inh_last = 1'b0;
   logic inh_prev = 1'b0;
   always @(negedge clock) begin
      if (clk_oe) begin
         inh_run++;
         inh_prev = inh_last;
         inh_last = data_oe;
      end else if (inh_run != 0) begin
         check("inhibit_len", inh_run, INH);
         check("start_in_last_inhibit", {inh_prev, inh_last}, 2'b01);
         inh_run = 0;
      end
   end

   task automatic issue(input logic [7:0] b);
      int t;
      t = 0;
      @(negedge clock);
      while (!tx_ready && t < 3000) begin
         @(negedge clock);
         t++;
      end
      tx_data  = b;
      tx_valid = 1'b1;
      @(posedge clock);
      #1;
      tx_valid = 1'b0;
      check("ready_drop", tx_ready, 1'b0);
      check("busy_rise", busy, 1'b1);
   endtask

   // mode: 0 normal, 1 no ack, 2 silent, 3 clock glitch, 4 stop after 5th fall
   task automatic device(input int mode);
      int t;
      t = 0;
      dev_bits = '1;
      while (!(clk_oe == 1'b0 && data_oe == 1'b1) && t < 2000) begin
         @(negedge clock);
         t++;
      end
      check("req_seen", (t < 2000), 1'b1);
      if (t >= 2000) return;
      if (mode == 2) begin
         t = 0;
         while (data_oe && t < 4 * TMO) begin
            @(negedge clock);
            t++;
         end
         check("timeout_latency", t, TMO);
         check("timeout_clk_release", clk_oe, 1'b0);
         return;
      end
      for (int k = 0; k < 11; k++) begin
         if (mode == 3 && k == 3) begin
            repeat (14) @(negedge clock);
            dev_clk_low = 1'b1;
            repeat (4) @(negedge clock);
            dev_clk_low = 1'b0;
            repeat (H - 18) @(negedge clock);
         end else begin
            repeat (H) @(negedge clock);
         end
         dev_bits[k] = ps2_data_line;
         if (k == 10) begin
            if (mode != 1) dev_data_low = 1'b1;
            repeat (5) @(negedge clock);
         end
         dev_clk_low = 1'b1;
         repeat (H) @(negedge clock);
         if (mode == 4 && k == 4) return;
         dev_clk_low = 1'b0;
      end
      dev_data_low = 1'b0;
   endtask

   task automatic wait_complete();
      int t;
      t = 0;
      while ((sb.size() != 0 || !tx_ready) && t < 3000) begin
         @(negedge clock);
         t++;
      end
      check("frame_complete", (t < 3000), 1'b1);
   endtask

   task automatic frame(input logic [7:0] b, input int mode, input exp_t e);
      sb.push_back(e);
      issue(b);
      device(mode);
      wait_complete();
   endtask

   initial begin
      rst          = 1'b1;
      tx_data      = 8'h00;
      tx_valid     = 1'b0;
      dev_clk_low  = 1'b0;
      dev_data_low = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_tx_ready", tx_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_ack_ok", ack_ok, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_clk_oe", clk_oe, 1'b0);
      check("rst_data_oe", data_oe, 1'b0);
      rst = 1'b0;
      repeat (20) @(negedge clock);

      frame(8'hED, 0, '{chk_bits: 1'b1, bits: ED_BITS, ack: 1'b1, err: 1'b0});
      frame(8'hF4, 0, '{chk_bits: 1'b1, bits: F4_BITS, ack: 1'b1, err: 1'b0});
      frame(8'hF4, 2, '{chk_bits: 1'b0, bits: 11'h0, ack: 1'b0, err: 1'b1});
      frame(8'hF4, 1, '{chk_bits: 1'b1, bits: F4_BITS, ack: 1'b0, err: 1'b1});
      frame(8'hED, 3, '{chk_bits: 1'b1, bits: ED_BITS, ack: 1'b1, err: 1'b0});

      // reset while the 5th data bit (0 for 0xED) is on the line
      issue(8'hED);
      device(4);
      check("bit4_data_oe", data_oe, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("abort_clk_oe", clk_oe, 1'b0);
      check("abort_data_oe", data_oe, 1'b0);
      check("abort_tx_ready", tx_ready, 1'b1);
      check("abort_busy", busy, 1'b0);
      dev_clk_low = 1'b0;
      repeat (3) @(negedge clock);
      rst = 1'b0;
      repeat (20) @(negedge clock);
      frame(8'hF4, 0, '{chk_bits: 1'b1, bits: F4_BITS, ack: 1'b1, err: 1'b0});

      // tx_valid held with another byte while busy must be ignored
      sb.push_back('{chk_bits: 1'b1, bits: ED_BITS, ack: 1'b1, err: 1'b0});
      issue(8'hED);
      tx_data  = 8'hAA;
      tx_valid = 1'b1;
      device(0);
      tx_valid = 1'b0;
      wait_complete();
      repeat (50) @(negedge clock);
      check("idle_after_hold", busy, 1'b0);

      check("done_count", done_count, 7);
      check("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no end of test expected $finish before %0t", $time);
      $fatal(1, "bench time limit");
   end

endmodule
